// File: rtl/maria_timing_gen.sv
// Video timing generator: pixel-enable divider, H/V raster counters, blanking/sync decode
// and a small test-pattern source. Outputs are registered and change only on pixel strobes.
module maria_timing_gen #(
  parameter int unsigned CE_DIV  = 4,
  parameter int unsigned H_TOTAL = 454
) (
  input  logic       clk_sys,
  input  logic       reset,
  input  logic       enable,
  input  logic       is_PAL,
  input  logic [1:0] pattern,
  input  logic [7:0] solid_color,
  output logic       maria_pix_ce,
  output logic [3:0] maria_luma,
  output logic [3:0] maria_chroma,
  output logic       maria_hblank,
  output logic       maria_vblank,
  output logic       maria_hsync,
  output logic       maria_vsync,
  output logic       frame_start
);

  // At least 9 bits so the pattern slices hcount[8:5] always exist.
  localparam int unsigned HW = ($clog2(H_TOTAL) > 9) ? $clog2(H_TOTAL) : 9;
  localparam int unsigned VW = 9;

  localparam logic [3:0]    DivLast    = 4'(CE_DIV - 1);
  localparam logic [HW-1:0] HLast      = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] HBlankBeg  = HW'(320);
  localparam logic [HW-1:0] HSyncBeg   = HW'(360);
  localparam logic [HW-1:0] HSyncEnd   = HW'(393);
  localparam logic [VW-1:0] VLastNtsc  = 9'd262;
  localparam logic [VW-1:0] VLastPal   = 9'd312;
  localparam logic [VW-1:0] VBlankNtsc = 9'd243;
  localparam logic [VW-1:0] VBlankPal  = 9'd292;
  localparam logic [VW-1:0] VSyncNtsc  = 9'd250;
  localparam logic [VW-1:0] VSyncPal   = 9'd300;

  logic [3:0]    div_q;
  logic [HW-1:0] hcount_q;
  logic [VW-1:0] vcount_q;
  logic          pal_q;

  logic          pix_ce;
  logic          h_wrap;
  logic          v_wrap;
  logic [VW-1:0] v_last;

  assign pix_ce       = enable && (div_q == DivLast);
  assign maria_pix_ce = pix_ce;
  assign v_last       = pal_q ? VLastPal : VLastNtsc;
  assign h_wrap       = (hcount_q == HLast);
  assign v_wrap       = (vcount_q == v_last);

  // The video mode is captured while in reset and otherwise only at the frame boundary.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      div_q    <= '0;
      hcount_q <= '0;
      vcount_q <= '0;
      pal_q    <= is_PAL;
    end else if (enable) begin
      div_q <= pix_ce ? '0 : div_q + 4'd1;
      if (pix_ce) begin
        hcount_q <= h_wrap ? '0 : hcount_q + 1'b1;
        if (h_wrap) begin
          vcount_q <= v_wrap ? '0 : vcount_q + 1'b1;
          if (v_wrap) pal_q <= is_PAL;
        end
      end
    end
  end

  logic       hblank_d;
  logic       vblank_d;
  logic       hsync_d;
  logic       vsync_d;
  logic       frame_start_d;
  logic [3:0] luma_d;
  logic [3:0] chroma_d;

  always_comb begin
    hblank_d      = (hcount_q >= HBlankBeg);
    hsync_d       = (hcount_q >= HSyncBeg) && (hcount_q <= HSyncEnd);
    vblank_d      = pal_q ? (vcount_q >= VBlankPal) : (vcount_q >= VBlankNtsc);
    vsync_d       = pal_q ? ((vcount_q >= VSyncPal) && (vcount_q <= VSyncPal + 9'd2))
                          : ((vcount_q >= VSyncNtsc) && (vcount_q <= VSyncNtsc + 9'd2));
    frame_start_d = (hcount_q == '0) && (vcount_q == '0);
    chroma_d      = 4'h0;
    luma_d        = 4'h0;
    unique case (pattern)
      2'd0: begin
        chroma_d = hcount_q[8:5];
        luma_d   = vcount_q[4:1];
      end
      2'd1: begin
        chroma_d = hcount_q[8:5];
        luma_d   = vcount_q[7:4];
      end
      2'd2: {chroma_d, luma_d} = solid_color;
      2'd3: luma_d = (hcount_q[3] ^ vcount_q[3]) ? 4'hF : 4'h0;
      default: ;
    endcase
    if (hblank_d || vblank_d) begin
      chroma_d = 4'h0;
      luma_d   = 4'h0;
    end
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      maria_luma   <= '0;
      maria_chroma <= '0;
      maria_hblank <= 1'b0;
      maria_vblank <= 1'b0;
      maria_hsync  <= 1'b0;
      maria_vsync  <= 1'b0;
      frame_start  <= 1'b0;
    end else if (pix_ce) begin
      maria_luma   <= luma_d;
      maria_chroma <= chroma_d;
      maria_hblank <= hblank_d;
      maria_vblank <= vblank_d;
      maria_hsync  <= hsync_d;
      maria_vsync  <= vsync_d;
      frame_start  <= frame_start_d;
    end
  end

endmodule

// File: tb/tb_maria_timing_gen.sv
// Scoreboard bench: dut_a (default geometry) covers horizontal timing, patterns, pause and
// reset; dut_b (8-pixel lines, CE_DIV=2) covers whole NTSC/PAL frames in few cycles.
module tb_maria_timing_gen;

  typedef struct {
    int          idx;
    logic [12:0] exp;
    string       nm;
  } exp_t;

  logic       clk_sys = 1'b0;
  logic       reset_a, reset_b, enable_a, enable_b, pal_a, pal_b;
  logic [1:0] pattern_a, pattern_b;
  logic [7:0] solid_a, solid_b;
  logic       ce_a, hb_a, vb_a, hs_a, vs_a, fs_a;
  logic       ce_b, hb_b, vb_b, hs_b, vs_b, fs_b;
  logic [3:0] luma_a, chroma_a, luma_b, chroma_b;
  logic [12:0] outs_a, outs_b;

  exp_t q_a[$];
  exp_t q_b[$];
  int   cnt_a = 0, cnt_b = 0;
  int   n_checks = 0, n_pass = 0;
  int   hb_line = 0, hs_line = 0;
  logic ce_a_n = 1'b0, ce_b_n = 1'b0;

  always #5 clk_sys = ~clk_sys;

  assign outs_a = {fs_a, hb_a, vb_a, hs_a, vs_a, chroma_a, luma_a};
  assign outs_b = {fs_b, hb_b, vb_b, hs_b, vs_b, chroma_b, luma_b};

  maria_timing_gen #(.CE_DIV(4), .H_TOTAL(454)) dut_a (
    .clk_sys(clk_sys), .reset(reset_a), .enable(enable_a), .is_PAL(pal_a),
    .pattern(pattern_a), .solid_color(solid_a), .maria_pix_ce(ce_a),
    .maria_luma(luma_a), .maria_chroma(chroma_a), .maria_hblank(hb_a),
    .maria_vblank(vb_a), .maria_hsync(hs_a), .maria_vsync(vs_a), .frame_start(fs_a)
  );

  maria_timing_gen #(.CE_DIV(2), .H_TOTAL(8)) dut_b (
    .clk_sys(clk_sys), .reset(reset_b), .enable(enable_b), .is_PAL(pal_b),
    .pattern(pattern_b), .solid_color(solid_b), .maria_pix_ce(ce_b),
    .maria_luma(luma_b), .maria_chroma(chroma_b), .maria_hblank(hb_b),
    .maria_vblank(vb_b), .maria_hsync(hs_b), .maria_vsync(vs_b), .frame_start(fs_b)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
  endtask

  // Expected vector layout: {frame_start, hblank, vblank, hsync, vsync, chroma, luma}.
  function automatic logic [12:0] px(input bit fs, input bit hb, input bit vb, input bit hs,
                                     input bit vs, input logic [3:0] c, input logic [3:0] l);
    return {fs, hb, vb, hs, vs, c, l};
  endfunction

  task automatic push(input int which, input int idx, input logic [12:0] e, input string nm);
    exp_t t;
    t.idx = idx;
    t.exp = e;
    t.nm  = nm;
    if (which == 0) q_a.push_back(t);
    else q_b.push_back(t);
  endtask

  // pix_ce is sampled mid-cycle; the outputs it produced are compared just after the edge.
  always @(negedge clk_sys) begin
    ce_a_n = ce_a;
    ce_b_n = ce_b;
  end

  always @(posedge clk_sys) begin
    if (ce_a_n) begin
      #1;
      while (q_a.size() > 0 && q_a[0].idx < cnt_a) begin
        check({q_a[0].nm, "_missed"}, cnt_a, q_a[0].idx);
        q_a.delete(0);
      end
      if (q_a.size() > 0 && q_a[0].idx == cnt_a) begin
        check(q_a[0].nm, 32'(outs_a), 32'(q_a[0].exp));
        q_a.delete(0);
      end
      if (cnt_a < 454) begin
        hb_line += int'(hb_a);
        hs_line += int'(hs_a);
      end
      if (cnt_a == 453) begin
        check("a_line_hblank_pixels", hb_line, 134);
        check("a_line_hsync_pixels", hs_line, 34);
      end
      cnt_a++;
    end
  end

  always @(posedge clk_sys) begin
    if (ce_b_n) begin
      #1;
      while (q_b.size() > 0 && q_b[0].idx < cnt_b) begin
        check({q_b[0].nm, "_missed"}, cnt_b, q_b[0].idx);
        q_b.delete(0);
      end
      if (q_b.size() > 0 && q_b[0].idx == cnt_b) begin
        check(q_b[0].nm, 32'(outs_b), 32'(q_b[0].exp));
        q_b.delete(0);
      end
      cnt_b++;
    end
  end

  task automatic wait_cnt(input int which, input int target, input string nm);
    for (int i = 0; i < 40000; i++) begin
      if (((which == 0) ? cnt_a : cnt_b) >= target) break;
      @(posedge clk_sys);
      #2;
    end
    check(nm, 32'(((which == 0) ? cnt_a : cnt_b) >= target), 32'd1);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got no finish by 900000 ns, required finish");
    $fatal(1);
  end

  initial begin
    logic [15:0] va, vb;
    logic [3:0]  rv;
    logic [12:0] snap;
    logic        stable;
    int          n, base;

    reset_a = 1'b1; reset_b = 1'b1; enable_a = 1'b1; enable_b = 1'b1;
    pal_a = 1'b0; pal_b = 1'b0; pattern_a = 2'd0; pattern_b = 2'd1;
    solid_a = 8'h00; solid_b = 8'h00;

    // dut_a line 0..3 expectations (pattern 0, then 2 from pixel 1011, then 3 from 1301)
    push(0, 0,    px(1, 0, 0, 0, 0, 4'h0, 4'h0), "a_pix_0_0");
    push(0, 37,   px(0, 0, 0, 0, 0, 4'h1, 4'h0), "a_bars_h37");
    push(0, 319,  px(0, 0, 0, 0, 0, 4'h9, 4'h0), "a_bars_h319");
    push(0, 320,  px(0, 1, 0, 0, 0, 4'h0, 4'h0), "a_hblank_h320");
    push(0, 359,  px(0, 1, 0, 0, 0, 4'h0, 4'h0), "a_h359");
    push(0, 360,  px(0, 1, 0, 1, 0, 4'h0, 4'h0), "a_hsync_h360");
    push(0, 393,  px(0, 1, 0, 1, 0, 4'h0, 4'h0), "a_hsync_h393");
    push(0, 394,  px(0, 1, 0, 0, 0, 4'h0, 4'h0), "a_h394");
    push(0, 453,  px(0, 1, 0, 0, 0, 4'h0, 4'h0), "a_h453");
    push(0, 454,  px(0, 0, 0, 0, 0, 4'h0, 4'h0), "a_line1_h0");
    push(0, 1008, px(0, 0, 0, 0, 0, 4'h3, 4'h1), "a_bars_v2_h100");
    push(0, 1100, px(0, 0, 0, 0, 0, 4'h4, 4'hA), "a_solid_h192");
    push(0, 1227, px(0, 0, 0, 0, 0, 4'h4, 4'hA), "a_solid_h319");
    push(0, 1228, px(0, 1, 0, 0, 0, 4'h0, 4'h0), "a_solid_h320");
    push(0, 1370, px(0, 0, 0, 0, 0, 4'h0, 4'hF), "a_checker_h8");
    push(0, 1378, px(0, 0, 0, 0, 0, 4'h0, 4'h0), "a_checker_h16");
    push(0, 1562, px(0, 0, 0, 0, 0, 4'h0, 4'hF), "a_resume_h200");

    // dut_b: NTSC frame (is_PAL raised at line 100), then a PAL frame at 2104
    push(1, 0,    px(1, 0, 0, 0, 0, 4'h0, 4'h0), "b_pix_0_0");
    push(1, 803,  px(0, 0, 0, 0, 0, 4'h0, 4'h6), "b_grid_v100");
    push(1, 1936, px(0, 0, 0, 0, 0, 4'h0, 4'hF), "b_ntsc_v242");
    push(1, 1944, px(0, 0, 1, 0, 0, 4'h0, 4'h0), "b_ntsc_vblank_v243");
    push(1, 1992, px(0, 0, 1, 0, 0, 4'h0, 4'h0), "b_ntsc_v249");
    push(1, 2000, px(0, 0, 1, 0, 1, 4'h0, 4'h0), "b_ntsc_vsync_v250");
    push(1, 2023, px(0, 0, 1, 0, 1, 4'h0, 4'h0), "b_ntsc_vsync_v252");
    push(1, 2024, px(0, 0, 1, 0, 0, 4'h0, 4'h0), "b_ntsc_v253");
    push(1, 2103, px(0, 0, 1, 0, 0, 4'h0, 4'h0), "b_ntsc_v262");
    push(1, 2104, px(1, 0, 0, 0, 0, 4'h0, 4'h0), "b_ntsc_frame_len");
    push(1, 4048, px(0, 0, 0, 0, 0, 4'h0, 4'hF), "b_pal_v243");
    push(1, 4104, px(0, 0, 0, 0, 0, 4'h0, 4'hF), "b_pal_v250");
    push(1, 4439, px(0, 0, 0, 0, 0, 4'h0, 4'h2), "b_pal_v291");
    push(1, 4440, px(0, 0, 1, 0, 0, 4'h0, 4'h0), "b_pal_vblank_v292");
    push(1, 4503, px(0, 0, 1, 0, 0, 4'h0, 4'h0), "b_pal_v299");
    push(1, 4504, px(0, 0, 1, 0, 1, 4'h0, 4'h0), "b_pal_vsync_v300");
    push(1, 4527, px(0, 0, 1, 0, 1, 4'h0, 4'h0), "b_pal_vsync_v302");
    push(1, 4528, px(0, 0, 1, 0, 0, 4'h0, 4'h0), "b_pal_v303");
    push(1, 4607, px(0, 0, 1, 0, 0, 4'h0, 4'h0), "b_pal_v312");
    push(1, 4608, px(1, 0, 0, 0, 0, 4'h0, 4'h0), "b_pal_frame_len");

    repeat (3) @(posedge clk_sys);
    #1;
    check("a_reset_outputs", {18'd0, ce_a, outs_a}, 32'd0);
    check("b_reset_outputs", {18'd0, ce_b, outs_b}, 32'd0);
    #1;
    reset_a = 1'b0;
    reset_b = 1'b0;
    for (int i = 0; i < 16; i++) begin
      @(posedge clk_sys);
      #1;
      va[i] = ce_a;
      vb[i] = ce_b;
      if (i == 3) check("a_first_frame_start", 32'(fs_a), 32'd1);
    end
    check("a_pix_ce_cadence", 32'(va), 32'h4444);
    check("b_pix_ce_cadence", 32'(vb), 32'h5555);
    #1;

    fork
      begin
        wait_cnt(0, 1011, "a_wait_pat2");
        pattern_a = 2'd2;
        solid_a   = 8'h4A;
        wait_cnt(0, 1301, "a_wait_pat3");
        pattern_a = 2'd3;
        wait_cnt(0, 1562, "a_wait_h200");
        repeat (2) @(posedge clk_sys);
        #2;
        enable_a = 1'b0;
        snap   = outs_a;
        stable = 1'b1;
        for (int i = 0; i < 50; i++) begin
          @(posedge clk_sys);
          #1;
          if (ce_a || outs_a !== snap) stable = 1'b0;
        end
        check("a_pause_stable", 32'(stable), 32'd1);
        check("a_pause_no_pixels", cnt_a, 1562);
        #1;
        enable_a = 1'b1;
        n = 0;
        for (int i = 0; i < 10; i++) begin
          @(posedge clk_sys);
          n++;
          #2;
          if (cnt_a != 1562) break;
        end
        check("a_resume_edges", n, 2);
        wait_cnt(0, 1763, "a_wait_h400");
        check("a_queue_drained", q_a.size(), 0);
        reset_a   = 1'b1;
        pattern_a = 2'd2;
        #1;
        check("a_reset_immediate", {18'd0, ce_a, outs_a}, 32'd0);
        repeat (3) @(posedge clk_sys);
        #2;
        reset_a = 1'b0;
        base = cnt_a;
        push(0, base,     px(1, 0, 0, 0, 0, 4'h4, 4'hA), "a_restart_pix_0_0");
        push(0, base + 1, px(0, 0, 0, 0, 0, 4'h4, 4'hA), "a_restart_pix_1_0");
        for (int i = 0; i < 4; i++) begin
          @(posedge clk_sys);
          #1;
          rv[i] = ce_a;
        end
        check("a_restart_cadence", 32'(rv), 32'h4);
        wait_cnt(0, base + 2, "a_wait_restart");
      end
      begin
        wait_cnt(1, 805, "b_wait_v100");
        pal_b = 1'b1;
        wait_cnt(1, 6612, "b_wait_v250");
        check("b_queue_drained", q_b.size(), 0);
        reset_b = 1'b1;
        pal_b   = 1'b0;
        #1;
        check("b_reset_immediate", {18'd0, ce_b, outs_b}, 32'd0);
        repeat (3) @(posedge clk_sys);
        #2;
        reset_b = 1'b0;
        base = cnt_b;
        push(1, base,        px(1, 0, 0, 0, 0, 4'h0, 4'h0), "b_restart_pix_0_0");
        push(1, base + 1936, px(0, 0, 0, 0, 0, 4'h0, 4'hF), "b_restart_ntsc_v242");
        push(1, base + 1944, px(0, 0, 1, 0, 0, 4'h0, 4'h0), "b_restart_ntsc_v243");
        for (int i = 0; i < 4; i++) begin
          @(posedge clk_sys);
          #1;
          rv[i] = ce_b;
          if (i == 1) check("b_restart_frame_start", 32'(fs_b), 32'd1);
        end
        check("b_restart_cadence", 32'(rv), 32'h5);
        wait_cnt(1, base + 1945, "b_wait_restart_v243");
      end
    join

    check("a_queue_empty_end", q_a.size(), 0);
    check("b_queue_empty_end", q_b.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/maria_timing_gen.md
MARIA_TIMING_GEN -- requirements
Module: maria_timing_gen

Interface
REQ-001 SHALL have parameter CE_DIV, default 4: clk_sys cycles per pixel enable; legal values 2..15.
REQ-002 SHALL have parameter H_TOTAL, default 454: pixel clocks per line.
REQ-003 SHALL have port clk_sys  input  1  system clock; all logic is clocked on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port enable  input  1  when high, the divider and counters advance.
REQ-006 SHALL have port is_PAL  input  1  selects 313-line PAL timing when high, 263-line NTSC timing when low.
REQ-007 SHALL have port pattern  input  2  test-pattern select.
REQ-008 SHALL have port solid_color  input  8  {chroma, luma} value used by pattern 2.
REQ-009 SHALL have port maria_pix_ce  output  1  one-clk_sys pixel strobe.
REQ-010 SHALL have ports maria_luma and maria_chroma  output  4 each  pixel color.
REQ-011 SHALL have ports maria_hblank, maria_vblank, maria_hsync and maria_vsync  output  1 each  timing signals, active high.
REQ-012 SHALL have port frame_start  output  1  high for the pix_ce cycle of pixel (0,0).

Function
REQ-013 SHALL use a divider counter div that runs 0..CE_DIV-1 and wraps, advancing only while enable is high.
REQ-014 SHALL assert maria_pix_ce for exactly the clk_sys cycle in which div==CE_DIV-1 and enable is high; maria_pix_ce is low at all other times.
REQ-015 SHALL keep hcount in 0..H_TOTAL-1 and advance it once per pix_ce; on wrap from H_TOTAL-1 to 0, vcount advances.
REQ-016 SHALL keep vcount in 0..V_TOTAL-1, with V_TOTAL=263 (NTSC) or 313 (PAL); vcount wraps from V_TOTAL-1 to 0.
REQ-017 SHALL sample is_PAL only when the frame wraps (hcount=H_TOTAL-1 and vcount=V_TOTAL-1 at pix_ce); a mid-frame change takes effect at the next frame.
REQ-018 SHALL register every video output and update it only in a pix_ce cycle, driven from the pre-increment (hcount, vcount) of that cycle; zero latency relative to pix_ce.
REQ-019 SHALL drive hblank = (hcount >= 320).
REQ-020 SHALL drive hsync = (360 <= hcount <= 393).
REQ-021 SHALL drive vblank = (vcount >= 243) for NTSC and (vcount >= 292) for PAL.
REQ-022 SHALL drive vsync = (vcount in 250..252) for NTSC and (vcount in 300..302) for PAL.
REQ-023 SHALL produce pattern 0 (bars): chroma = hcount[8:5], luma = vcount[4:1].
REQ-024 SHALL produce pattern 1 (grid): chroma = hcount[8:5], luma = vcount[7:4].
REQ-025 SHALL produce pattern 2 (solid): {chroma, luma} = solid_color.
REQ-026 SHALL produce pattern 3 (checker): luma = 4'hF if hcount[3]^vcount[3], else 4'h0; chroma = 0.
REQ-027 SHALL force luma and chroma to 0 whenever hblank or vblank is true for the pixel.
REQ-028 SHALL sample pattern and solid_color every pix_ce with no holding.
REQ-029 SHALL, while enable is low, freeze div, hcount, vcount and all outputs, keeping pix_ce low; on re-enable, counting resumes from the frozen div value.
REQ-030 SHALL assert frame_start with the pix_ce that emits (hcount=0, vcount=0).

Reset
REQ-031 SHALL, while reset is high, clear div, hcount, vcount and every output to 0 asynchronously, and load the latched PAL mode from is_PAL.
REQ-032 SHALL, after reset deasserts with enable high, assert the first pix_ce on the CE_DIV-th rising edge, outputting pixel (0,0) with frame_start=1.
REQ-033 SHALL, on reset asserted mid-line or mid-frame, abort the frame immediately with no completion of the line.

Verification
REQ-034 SHALL verify: CE_DIV=4 with enable held high -> pix_ce has a period of 4 cycles and width 1; first pix_ce on the 4th edge after reset with frame_start=1.
REQ-035 SHALL verify: NTSC frame -> 263x454 pix_ce per frame; hblank 134 pixels/line; hsync 34 pixels; vblank lines 243..262; vsync lines 250..252.
REQ-036 SHALL verify: is_PAL toggled 0->1 at vcount=100 -> the current frame completes as 263 lines and the next frame has 313 lines, with vsync at 300..302.
REQ-037 SHALL verify: pattern 2, solid_color=8'h4A -> chroma=4, luma=A on visible pixels; at hcount=320, both are 0.
REQ-038 SHALL verify: enable low for 50 cycles at hcount=200 -> no pix_ce and outputs stable; resume yields hcount=200 output at the next pix_ce.
REQ-039 SHALL verify: reset pulse at hcount=400, vcount=250 -> outputs 0 immediately; the restart emits pixel (0,0) on the CE_DIV-th edge.
